// File: rtl/reset_seq_pkg.sv
// Shared encodings and constants for the platform reset sequencer.
// Imported by the sequencer top and its interface.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HELD    = 2'd0,
        INIT    = 2'd1,
        STAGGER = 2'd2,
        RUN     = 2'd3
    } seq_state_e;

    // Level meaning "resume-well power is good" on the filtered RSMRST_N
    localparam logic PWR_SW_ON = 1'b1;
    localparam logic HIGH      = 1'b1;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/reset_sequencer_if.sv
// Source qualification inputs and sequenced reset outputs of the reset sequencer.
// master = sequencer side, slave = consumer/board side.
interface reset_sequencer_if #(
    parameter int unsigned NUM_CH = 4
);

    logic                     RSMRST_N;
    logic                     PLTRST_N;
    logic                     SwReqSeq;
    logic                     Tick;
    logic                     InitResetn;
    logic                     MainResetN;
    logic [NUM_CH-1:0]        ChResetN;
    logic                     SeqDone;
    reset_seq_pkg::seq_state_e SeqState;

    modport master (
        input  RSMRST_N, PLTRST_N, SwReqSeq,
        output Tick, InitResetn, MainResetN, ChResetN, SeqDone, SeqState
    );

    modport slave (
        output RSMRST_N, PLTRST_N, SwReqSeq,
        input  Tick, InitResetn, MainResetN, ChResetN, SeqDone, SeqState
    );

endinterface

// File: rtl/reset_tick_div.sv
// Tick strobe generator: one-cycle pulse every TICK_DIV clocks, restartable via reload.
module reset_tick_div #(
    parameter int unsigned TICK_DIV = 503
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    output logic tick
);

    localparam int unsigned      DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] LOAD  = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] cnt;

    // tick is registered so it is high exactly while cnt sits at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= LOAD;
            tick <= 1'b0;
        end else begin
            tick <= !reload && (cnt == DIV_W'(1));
            if (reload || (cnt == '0)) begin
                cnt <= LOAD;
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Power-on/platform reset sequencer: qualifies RSMRST_N/PLTRST_N, holds InitResetn
// for INIT_TICKS ticks, then releases NUM_CH channel resets STAGGER_TICKS apart.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned TICK_DIV      = 503,
    parameter int unsigned INIT_TICKS    = 32,
    parameter int unsigned STAGGER_TICKS = 4,
    parameter int unsigned FILT_LEN      = 3,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                MCLKi,
    input  logic                HARD_nRESETi,
    reset_sequencer_if.master   bus
);

    localparam int unsigned NUM_SRC = 2;
    localparam int unsigned FILT_W  = $clog2(FILT_LEN + 1);
    localparam bit          DIRECT  = (STAGGER_TICKS == 0) || (NUM_CH == 1);

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_TICKS - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'((NUM_CH - 1) * STAGGER_TICKS);

    logic [NUM_SRC-1:0] src_raw;
    logic [NUM_SRC-1:0] src_f;
    logic               rsm_f;
    logic               plt_f;

    seq_state_e         state;
    seq_state_e         state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic [CNT_W-1:0]   cnt_inc_c;
    logic [NUM_CH-1:0]  rel;
    logic [NUM_CH-1:0]  rel_nx;
    logic               init_nx;
    logic               reload_c;
    logic               tick;

    logic               init_q;
    logic               main_q;
    logic [NUM_CH-1:0]  ch_q;
    logic               done_q;

    assign src_raw = {bus.PLTRST_N, bus.RSMRST_N};
    assign rsm_f   = src_f[0];
    assign plt_f   = src_f[1];

    // Per-source synchroniser plus run-length glitch filter; filtered value starts asserted (0)
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [SYNC_STAGES-1:0] sync;
        logic [FILT_W-1:0]      run_len;
        logic                   filt;

        always_ff @(posedge MCLKi or negedge HARD_nRESETi) begin
            if (!HARD_nRESETi) begin
                sync    <= '0;
                run_len <= '0;
                filt    <= 1'b0;
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], src_raw[g]};
                if (sync[SYNC_STAGES-1] == filt) begin
                    run_len <= '0;
                end else if (run_len == FILT_W'(FILT_LEN)) begin
                    filt    <= sync[SYNC_STAGES-1];
                    run_len <= '0;
                end else begin
                    run_len <= run_len + FILT_W'(1);
                end
            end
        end

        assign src_f[g] = filt;
    end

    reset_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk    (MCLKi),
        .rst_n  (HARD_nRESETi),
        .reload (reload_c),
        .tick   (tick)
    );

    // Next-state, tick counter and channel release pattern
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        rel_nx    = rel;
        reload_c  = 1'b0;
        init_nx   = 1'b0;
        cnt_inc_c = (cnt == '1) ? cnt : cnt + CNT_W'(1);

        // Loss of resume-well power overrides everything else
        if (rsm_f != PWR_SW_ON) begin
            state_nx = HELD;
            cnt_nx   = '0;
            rel_nx   = '0;
        end else begin
            case (state)
                HELD: begin
                    state_nx = INIT;
                    cnt_nx   = '0;
                    rel_nx   = '0;
                    reload_c = 1'b1;
                end
                INIT: begin
                    if (tick) begin
                        if (cnt == INIT_LAST) begin
                            cnt_nx = '0;
                            if (DIRECT) begin
                                state_nx = RUN;
                                rel_nx   = '1;
                            end else begin
                                state_nx = STAGGER;
                                rel_nx   = NUM_CH'(1);
                            end
                        end else begin
                            cnt_nx = cnt_inc_c;
                        end
                    end
                end
                STAGGER: begin
                    if (tick) begin
                        cnt_nx = cnt_inc_c;
                        for (int i = 1; i < NUM_CH; i++) begin
                            if (cnt_inc_c >= CNT_W'(i * STAGGER_TICKS)) begin
                                rel_nx[i] = HIGH;
                            end
                        end
                        if (cnt_inc_c >= STAG_LAST) begin
                            state_nx = RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.SwReqSeq) begin
                        state_nx = HELD;
                        cnt_nx   = '0;
                        rel_nx   = '0;
                    end
                end
                default: begin
                    state_nx = HELD;
                end
            endcase
        end

        init_nx = (state_nx == STAGGER) || (state_nx == RUN);
    end

    // State and registered outputs; PLTRST_N gating applied on the same edge as the pattern
    always_ff @(posedge MCLKi or negedge HARD_nRESETi) begin
        if (!HARD_nRESETi) begin
            state  <= HELD;
            cnt    <= '0;
            rel    <= '0;
            init_q <= 1'b0;
            main_q <= 1'b0;
            ch_q   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            rel    <= rel_nx;
            init_q <= init_nx;
            main_q <= init_nx & plt_f;
            ch_q   <= rel_nx & {NUM_CH{plt_f}};
            done_q <= (state_nx == RUN);
        end
    end

    assign bus.Tick       = tick;
    assign bus.InitResetn = init_q;
    assign bus.MainResetN = main_q;
    assign bus.ChResetN   = ch_q;
    assign bus.SeqDone    = done_q;
    assign bus.SeqState   = state;

endmodule
